// File: rtl/dbg_uart_pkg.sv
// dbg_uart_pkg: FSM encoding, frame constants and helpers shared by the debug UART transmitter.
// DBG_UART_TX_PARITY_EN adds the PARITY state to the encoding.
package dbg_uart_pkg;

    localparam int unsigned DATA_BITS  = 32'd8;
    localparam int unsigned START_BITS = 32'd1;
    localparam int unsigned STOP_BITS  = 32'd1;

`ifdef DBG_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } tx_state_e;
`endif

    function automatic int unsigned frame_len(input int unsigned div, input bit parity_en);
        return div * (START_BITS + DATA_BITS + (parity_en ? 32'd1 : 32'd0) + STOP_BITS);
    endfunction

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dbg_uart_fifo.sv
// dbg_uart_fifo: synchronous FIFO with wrap-bit pointers; level excludes nothing but stored entries.
module dbg_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_s;
    logic             pop_s;

    assign push_s  = push & ~full;
    assign pop_s   = pop & ~empty;
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign level   = wr_ptr_r - rd_ptr_r;
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Storage array; validity is tracked by the pointers, so entries need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/dbg_uart_tx.sv
// dbg_uart_tx: FIFO-buffered UART transmitter, DIV clocks per bit, clk_921600 domain only.
// Define DBG_UART_TX_PARITY_EN for 8E1 frames; otherwise frames are 8N1.
module dbg_uart_tx
    import dbg_uart_pkg::*;
#(
    parameter int DIV     = 8,
    parameter int FIFO_AW = 4
) (
    input  logic               clk_921600,
    input  logic               rst,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               txd,
    output logic               busy,
    output logic [FIFO_AW:0]   level
);
    localparam int TW = $clog2(DIV);
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(DIV - 1);

    tx_state_e     state_r, state_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [2:0]    bit_idx_r, bit_idx_s;
    logic [7:0]    shift_r, shift_s;
    logic          txd_r, txd_s;
    logic          busy_r;
    logic          push_s, pop_s, full_s, empty_s;
    logic [7:0]    fifo_data_s;
`ifdef DBG_UART_TX_PARITY_EN
    logic          parity_r, parity_s;
`endif

    assign tx_ready = ~full_s;
    assign push_s   = tx_valid & ~full_s;
    assign txd      = txd_r;
    assign busy     = busy_r;

    dbg_uart_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_fifo (
        .clk     (clk_921600),
        .rst     (rst),
        .push    (push_s),
        .wr_data (tx_data),
        .pop     (pop_s),
        .rd_data (fifo_data_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (level)
    );

    // Frame sequencer: txd_s is the line value for the state being entered.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        txd_s     = 1'b1;
        pop_s     = 1'b0;
`ifdef DBG_UART_TX_PARITY_EN
        parity_s  = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = fifo_data_s;
                    timer_s = TIMER_RELOAD;
                    state_s = ST_START;
                    txd_s   = 1'b0;
`ifdef DBG_UART_TX_PARITY_EN
                    parity_s = even_parity(fifo_data_s);
`endif
                end else begin
                    txd_s = 1'b1;
                end
            end
            ST_START: begin
                if (timer_r == {TW{1'b0}}) begin
                    timer_s   = TIMER_RELOAD;
                    bit_idx_s = 3'd0;
                    state_s   = ST_DATA;
                    txd_s     = shift_r[0];
                end else begin
                    timer_s = timer_r - TW'(1);
                    txd_s   = 1'b0;
                end
            end
            ST_DATA: begin
                if (timer_r == {TW{1'b0}}) begin
                    timer_s = TIMER_RELOAD;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
`ifdef DBG_UART_TX_PARITY_EN
                        state_s = ST_PARITY;
                        txd_s   = parity_r;
`else
                        state_s = ST_STOP;
                        txd_s   = 1'b1;
`endif
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        txd_s     = shift_r[1];
                    end
                end else begin
                    timer_s = timer_r - TW'(1);
                    txd_s   = shift_r[0];
                end
            end
`ifdef DBG_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (timer_r == {TW{1'b0}}) begin
                    timer_s = TIMER_RELOAD;
                    state_s = ST_STOP;
                    txd_s   = 1'b1;
                end else begin
                    timer_s = timer_r - TW'(1);
                    txd_s   = parity_r;
                end
            end
`endif
            ST_STOP: begin
                if (timer_r == {TW{1'b0}}) begin
                    // Next byte already waiting: start bit follows the stop bit with no gap.
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        shift_s = fifo_data_s;
                        timer_s = TIMER_RELOAD;
                        state_s = ST_START;
                        txd_s   = 1'b0;
`ifdef DBG_UART_TX_PARITY_EN
                        parity_s = even_parity(fifo_data_s);
`endif
                    end else begin
                        state_s = ST_IDLE;
                        txd_s   = 1'b1;
                    end
                end else begin
                    timer_s = timer_r - TW'(1);
                    txd_s   = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                txd_s   = 1'b1;
            end
        endcase
    end

    // Sequencer and output flops; reset drives the line idle without waiting for a clock.
    always_ff @(posedge clk_921600 or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            timer_r   <= {TW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            txd_r     <= txd_s;
            busy_r    <= (state_s != ST_IDLE);
        end
    end

`ifdef DBG_UART_TX_PARITY_EN
    // Parity of the byte in the shifter, captured at load before shifting destroys it.
    always_ff @(posedge clk_921600 or posedge rst) begin
        if (rst) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= parity_s;
        end
    end
`endif

endmodule

// File: tb/tb_dbg_uart_tx.sv
// tb_dbg_uart_tx: directed self-checking bench for dbg_uart_tx (DIV=8 and DIV=2 instances).
// Honors DBG_UART_TX_PARITY_EN for 8E1 expectations.
module tb_dbg_uart_tx;
`ifdef DBG_UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int DIV    = 8;
    localparam int FRAME  = PAR ? 88 : 80;
    localparam int FRAME2 = PAR ? 22 : 20;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, txd, busy;
    logic [4:0] level;
    logic [7:0] tx_data2  = 8'h00;
    logic       tx_valid2 = 1'b0;
    logic       tx_ready2, txd2, busy2;
    logic [4:0] level2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int stop_bad = 0;
    logic [7:0] rx_q[$];
    logic       rx_par_q[$];
    int         rx_start_q[$];

    dbg_uart_tx #(.DIV(8), .FIFO_AW(4)) dut (
        .clk_921600 (clk), .rst (rst), .tx_data (tx_data), .tx_valid (tx_valid),
        .tx_ready (tx_ready), .txd (txd), .busy (busy), .level (level)
    );

    dbg_uart_tx #(.DIV(2), .FIFO_AW(4)) dut2 (
        .clk_921600 (clk), .rst (rst), .tx_data (tx_data2), .tx_valid (tx_valid2),
        .tx_ready (tx_ready2), .txd (txd2), .busy (busy2), .level (level2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected line value j cycles after the push edge, for an idle transmitter.
    function automatic logic exp_txd(input logic [7:0] b, input int j, input int div);
        int bit_no;
        if (j < 1) return 1'b1;
        bit_no = (j - 1) / div;
        if (bit_no == 0) return 1'b0;
        if (bit_no <= 8) return b[bit_no-1];
        if (PAR && bit_no == 9) return ^b;
        return 1'b1;
    endfunction

    // Mid-bit sampling receiver on the DIV=8 line.
    initial begin : rx_monitor
        logic       act;
        int         cnt;
        logic [7:0] sh;
        logic       par;
        act = 1'b0; cnt = 0; sh = 8'h00; par = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 1'b0;
            end else if (!act) begin
                if (txd === 1'b0) begin
                    act = 1'b1; cnt = 1; rx_start_q.push_back(cyc);
                end
            end else begin
                cnt++;
                for (int k = 0; k < 8; k++) if (cnt == (k + 1) * DIV + DIV / 2) sh[k] = txd;
                if (cnt == 9 * DIV + DIV / 2) par = txd;
                if (cnt == FRAME - DIV / 2 && txd !== 1'b1) stop_bad++;
                if (cnt == FRAME) begin
                    act = 1'b0; rx_q.push_back(sh); rx_par_q.push_back(par);
                end
            end
        end
    end

    task automatic clear_rx();
        rx_q.delete(); rx_par_q.delete(); rx_start_q.delete();
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((busy !== 1'b0 || level !== 5'd0) && guard < 30 * FRAME) begin
            @(negedge clk); guard++;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle busy=%b level=%0d", busy, level); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", tx_ready); end
        checks++; if (txd2 !== 1'b1) begin errors++; $display("FAIL reset_txd2 got %b exp 1", txd2); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (txd !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle txd=%b busy=%b exp 1/0", txd, busy); end
    endtask

    task automatic test_single(input logic [7:0] b, input logic exp_par);
        int busy_cnt = 0;
        clear_rx();
        tx_data = b; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level_push got %0d exp 1", level); end
        for (int j = 0; j <= FRAME + 4; j++) begin
            if (j > 0) @(negedge clk);
            checks++;
            if (txd !== exp_txd(b, j, DIV)) begin
                errors++; $display("FAIL single_txd byte %02h cycle %0d got %b exp %b", b, j, txd, exp_txd(b, j, DIV));
            end
            if (busy === 1'b1) busy_cnt++;
            if (j == 1) begin
                checks++; if (level !== 5'd0) begin errors++; $display("FAIL single_level_pop got %0d exp 0", level); end
            end
        end
        checks++; if (busy_cnt != FRAME) begin errors++; $display("FAIL single_busy_len got %0d exp %0d", busy_cnt, FRAME); end
        checks++;
        if (rx_q.size() != 1) begin
            errors++; $display("FAIL single_rx_count got %0d exp 1", rx_q.size());
        end else if (rx_q[0] !== b) begin
            errors++; $display("FAIL single_rx_byte got %02h exp %02h", rx_q[0], b);
        end
`ifdef DBG_UART_TX_PARITY_EN
        checks++;
        if (rx_par_q.size() != 1 || rx_par_q[0] !== exp_par) begin
            errors++; $display("FAIL single_parity byte %02h exp %b", b, exp_par);
        end
`else
        if (exp_par === 1'bx) $display("note: parity not built");
`endif
    endtask

    task automatic test_burst();
        int   n = 0;
        int   guard = 0;
        int   lvl_max = 0;
        logic ready_seen;
        clear_rx();
        tx_valid = 1'b1; tx_data = 8'h00;
        while (n < 17 && guard < 100) begin
            ready_seen = tx_ready;
            @(negedge clk); guard++;
            if (int'(level) > lvl_max) lvl_max = int'(level);
            if (ready_seen) begin n++; tx_data = 8'(n); end
        end
        tx_valid = 1'b0;
        checks++; if (n != 17) begin errors++; $display("FAIL burst_accepted got %0d exp 17", n); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL burst_ready_drop got %b exp 0", tx_ready); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL burst_level_full got %0d exp 16", level); end
        guard = 0;
        while (rx_q.size() < 17 && guard < 17 * FRAME + 200) begin
            @(negedge clk); guard++;
            if (int'(level) > lvl_max) lvl_max = int'(level);
        end
        checks++; if (rx_q.size() != 17) begin errors++; $display("FAIL burst_rx_count got %0d exp 17", rx_q.size()); end
        for (int i = 0; i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== 8'(i)) begin errors++; $display("FAIL burst_order idx %0d got %02h exp %02h", i, rx_q[i], 8'(i)); end
        end
        for (int i = 1; i < rx_start_q.size(); i++) begin
            checks++;
            if (rx_start_q[i] - rx_start_q[i-1] != FRAME) begin
                errors++; $display("FAIL burst_gap idx %0d got %0d exp %0d", i, rx_start_q[i] - rx_start_q[i-1], FRAME);
            end
        end
        checks++; if (lvl_max != 16) begin errors++; $display("FAIL burst_level_peak got %0d exp 16", lvl_max); end
        checks++; if (stop_bad != 0) begin errors++; $display("FAIL burst_stop_bits got %0d bad exp 0", stop_bad); end
    endtask

    task automatic test_simul_push_pop();
        int guard = 0;
        logic [7:0] exp_b [5];
        exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4; exp_b[4] = 8'hE5;
        wait_idle();
        clear_rx();
        tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data = exp_b[i]; @(negedge clk);
        end
        tx_valid = 1'b0;
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL simul_level_setup got %0d exp 3", level); end
        repeat (FRAME - 3) @(negedge clk);
        checks++; if (busy !== 1'b1 || txd !== 1'b1) begin errors++; $display("FAIL simul_in_stop busy=%b txd=%b exp 1/1", busy, txd); end
        tx_data = exp_b[4]; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL simul_level_hold got %0d exp 3", level); end
        checks++; if (txd !== 1'b0) begin errors++; $display("FAIL simul_next_start got %b exp 0", txd); end
        while (rx_q.size() < 5 && guard < 5 * FRAME + 100) begin
            @(negedge clk); guard++;
        end
        checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL simul_rx_count got %0d exp 5", rx_q.size()); end
        for (int i = 0; i < rx_q.size() && i < 5; i++) begin
            checks++; if (rx_q[i] !== exp_b[i]) begin errors++; $display("FAIL simul_order idx %0d got %02h exp %02h", i, rx_q[i], exp_b[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int low_cnt = 0;
        wait_idle();
        clear_rx();
        tx_valid = 1'b1;
        tx_data = 8'hA5; @(negedge clk);
        tx_data = 8'h11; @(negedge clk);
        tx_data = 8'h22; @(negedge clk);
        tx_valid = 1'b0;
        checks++; if (level !== 5'd2) begin errors++; $display("FAIL midrst_queued got %0d exp 2", level); end
        repeat (41) @(negedge clk);
        checks++; if (txd !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL midrst_bit4 txd=%b busy=%b exp 0/1", txd, busy); end
        rst = 1'b1;
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midrst_txd_async got %b exp 1", txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL midrst_level got %0d exp 0", level); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", tx_ready); end
        @(negedge clk);
        rst = 1'b0;
        clear_rx();
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (txd !== 1'b1) low_cnt++;
        end
        checks++; if (low_cnt != 0) begin errors++; $display("FAIL midrst_quiet got %0d low cycles exp 0", low_cnt); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL midrst_no_frames got %0d exp 0", rx_q.size()); end
        checks++; if (busy !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL midrst_after busy=%b level=%0d exp 0/0", busy, level); end
    endtask

    task automatic test_div2();
        int busy_cnt = 0;
        tx_data2 = 8'hFF; tx_valid2 = 1'b1;
        @(negedge clk);
        tx_valid2 = 1'b0;
        for (int j = 0; j <= FRAME2 + 3; j++) begin
            if (j > 0) @(negedge clk);
            checks++;
            if (txd2 !== exp_txd(8'hFF, j, 2)) begin
                errors++; $display("FAIL div2_txd cycle %0d got %b exp %b", j, txd2, exp_txd(8'hFF, j, 2));
            end
            if (busy2 === 1'b1) busy_cnt++;
        end
        checks++; if (busy_cnt != FRAME2) begin errors++; $display("FAIL div2_frame_len got %0d exp %0d", busy_cnt, FRAME2); end
    endtask

    initial begin
        test_reset();
        test_single(8'h55, 1'b0);
        test_single(8'h07, 1'b1);
        test_burst();
        test_simul_push_pop();
        test_reset_mid();
        test_div2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
